// File: rtl/knn_mem_pkg.sv
// Shared types and helpers for the KNN memory responder.
// Host FSM states, address-to-index mapping, read latency limits.
package knn_mem_pkg;

  typedef enum logic [1:0] {
    H_IDLE,
    H_ACK,
    H_WAIT
  } host_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  function automatic int unsigned addr_to_idx(
    input int unsigned addr,
    input int unsigned stride
  );
    return addr / stride;
  endfunction

  function automatic logic addr_misaligned(
    input int unsigned addr,
    input int unsigned stride
  );
    return (addr % stride) != 0;
  endfunction

  function automatic logic rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/knn_rd_delay_pipe.sv
// Valid+data shift register that stretches the array read path
// out to the configured read latency.
module knn_rd_delay_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [W-1:0]      data_q [STAGES];
    logic [W-1:0]      data_d [STAGES];

    always_comb begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        for (int i = 0; i < STAGES; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        valid_q <= valid_d;
        for (int i = 0; i < STAGES; i++) begin
          data_q[i] <= data_d[i];
        end
      end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
  end

endmodule

// File: rtl/knn_memory_responder.sv
// Memory-side responder for the KNN read/write strobe bus,
// with a lower-priority host port for preload and result dump.
module knn_memory_responder
  import knn_mem_pkg::*;
#(
  parameter int W           = 16,
  parameter int ADDR_W      = 16,
  parameter int ADDR_STRIDE = 16,
  parameter int DEPTH       = 1024,
  parameter int RD_LATENCY  = 2,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        readaddress,
  output logic [W-1:0]             readdata,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        writeaddress,
  input  logic [W-1:0]             writedata,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_idx,
  input  logic [W-1:0]             host_wdata,
  output logic                     host_ack,
  output logic [W-1:0]             host_rdata,
  output logic                     err_align,
  output logic                     err_range,
  output logic [CNT_W-1:0]         rd_count,
  output logic [CNT_W-1:0]         wr_count
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam int unsigned DEPTH_U = DEPTH;

  if (!rd_lat_legal(RD_LATENCY)) begin : g_bad_rd_latency
    $error("knn_memory_responder: RD_LATENCY must be 1..3");
  end

  logic [W-1:0] mem [DEPTH];

  int unsigned      rd_word;
  int unsigned      wr_word;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_in_range;
  logic             wr_in_range;
  logic             rd_misal;
  logic             wr_misal;

  always_comb begin
    rd_word     = addr_to_idx(32'(readaddress), ADDR_STRIDE);
    wr_word     = addr_to_idx(32'(writeaddress), ADDR_STRIDE);
    rd_idx      = rd_word[IDX_W-1:0];
    wr_idx      = wr_word[IDX_W-1:0];
    rd_in_range = rd_word < DEPTH_U;
    wr_in_range = wr_word < DEPTH_U;
    rd_misal    = addr_misaligned(32'(readaddress), ADDR_STRIDE);
    wr_misal    = addr_misaligned(32'(writeaddress), ADDR_STRIDE);
  end

  host_state_e state_q;
  logic        host_ack_q;
  logic [W-1:0] host_rdata_q;
  logic        host_go;

  // Host only touches the array on a cycle with no bus strobe.
  assign host_go = !rst && host_req && !read && !write
                && (state_q == H_IDLE);

  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [W-1:0]     mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = wr_idx;
    mem_wdata = writedata;
    if (!rst && write && wr_in_range) begin
      mem_we = 1'b1;
    end else if (host_go && host_we) begin
      mem_we    = 1'b1;
      mem_widx  = host_idx;
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  logic             ar_valid_q;
  logic             ar_valid_d;
  logic [W-1:0]     ar_data_q;
  logic [W-1:0]     ar_data_d;
  logic             pipe_valid;
  logic [W-1:0]     pipe_data;
  logic [W-1:0]     readdata_q;
  logic [W-1:0]     readdata_d;
  logic             err_align_q;
  logic             err_align_d;
  logic             err_range_q;
  logic             err_range_d;
  logic [CNT_W-1:0] rd_count_q;
  logic [CNT_W-1:0] rd_count_d;
  logic [CNT_W-1:0] wr_count_q;
  logic [CNT_W-1:0] wr_count_d;

  // Array is sampled before this edge's write lands: read-first.
  always_comb begin
    ar_valid_d  = read;
    ar_data_d   = rd_in_range ? mem[rd_idx] : '0;
    readdata_d  = pipe_valid ? pipe_data : readdata_q;
    err_align_d = err_align_q
                | (read && rd_misal)
                | (write && wr_misal);
    err_range_d = err_range_q
                | (read && !rd_in_range)
                | (write && !wr_in_range);
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    if (read && !(&rd_count_q)) begin
      rd_count_d = rd_count_q + CNT_W'(1);
    end
    if (write && !(&wr_count_q)) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  knn_rd_delay_pipe #(
    .W      (W),
    .STAGES (RD_LATENCY - 1)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ar_valid_q),
    .in_data   (ar_data_q),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_valid_q  <= 1'b0;
      ar_data_q   <= '0;
      readdata_q  <= '0;
      err_align_q <= 1'b0;
      err_range_q <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      ar_valid_q  <= ar_valid_d;
      ar_data_q   <= ar_data_d;
      readdata_q  <= readdata_d;
      err_align_q <= err_align_d;
      err_range_q <= err_range_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // H_WAIT holds off re-arbitration until the request drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= H_IDLE;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      unique case (state_q)
        H_IDLE: begin
          host_ack_q <= 1'b0;
          if (host_go) begin
            if (!host_we) begin
              host_rdata_q <= mem[host_idx];
            end
            state_q <= H_ACK;
          end
        end
        H_ACK: begin
          host_ack_q <= 1'b1;
          state_q    <= H_WAIT;
        end
        H_WAIT: begin
          host_ack_q <= 1'b0;
          if (!host_req) begin
            state_q <= H_IDLE;
          end
        end
        default: begin
          host_ack_q <= 1'b0;
          state_q    <= H_IDLE;
        end
      endcase
    end
  end

  assign readdata   = readdata_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign err_align  = err_align_q;
  assign err_range  = err_range_q;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;

endmodule
